// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the level-tracking synchronous FIFO.
// Holds read-mode encodings, default almost-full/empty thresholds and the level-width rule.
package fifo_pkg;

  localparam int unsigned FwftStd = 0;
  localparam int unsigned FwftOn  = 1;

  localparam int unsigned AeLevelDefault = 2;

  // Level counts 0..DEPTH inclusive, so it needs one bit more than the address.
  function automatic int unsigned level_width(input int unsigned addr_exp);
    return addr_exp + 32'd1;
  endfunction

  function automatic int unsigned af_level_default(input int unsigned addr_exp);
    return (32'd1 << addr_exp) - 32'd2;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port, one registered read port.
// Memory contents are never reset; only the read register is.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned Depth = 32'd1 << ADDR_W;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read-first: a same-address write in this cycle is not seen by this read.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with fill level, almost-full/empty flags, flush and sticky error flags.
// FWFT mode adds a prefetch register behind the RAM read register so the head word is presented.
module sync_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_EXP   = 4,
  parameter int unsigned FWFT       = FwftStd,
  parameter int unsigned AF_LEVEL   = af_level_default(ADDR_EXP),
  parameter int unsigned AE_LEVEL   = AeLevelDefault
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  FLUSH,
  input  logic                  CLR_ERR,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  PUSH,
  input  logic                  POP,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_EXP:0]     LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int unsigned LW     = level_width(ADDR_EXP);
  localparam int unsigned Depth  = 32'd1 << ADDR_EXP;
  localparam bit          IsFwft = (FWFT == FwftOn);

  logic [LW-1:0]         r_wr_ptr;
  logic [LW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  r_dvalid;
  logic [DATA_WIDTH-1:0] r_pf;
  logic                  r_pf_vld;
  logic                  r_ram_vld;

  logic                  w_empty;
  logic                  w_acc_pop;
  logic                  w_acc_push;
  logic                  w_ovf_evt;
  logic                  w_unf_evt;
  logic                  w_re;
  logic                  w_move;
  logic [LW-1:0]         w_unread;
  logic [LW-1:0]         w_level_d;
  logic [DATA_WIDTH-1:0] w_rdata;

  // In FWFT mode a word is only poppable once it sits in the prefetch register.
  assign w_empty    = IsFwft ? ~r_pf_vld : r_empty;
  assign w_acc_pop  = POP & ~w_empty & ~FLUSH;
  assign w_acc_push = PUSH & (~r_full | w_acc_pop) & ~FLUSH;
  assign w_ovf_evt  = PUSH & ~FLUSH & ~w_acc_push;
  assign w_unf_evt  = POP & ~FLUSH & w_empty;

  // FWFT pipeline: RAM read register (r_ram_vld) feeds the prefetch register (r_pf_vld).
  assign w_unread = r_wr_ptr - r_rd_ptr;
  assign w_move   = IsFwft & r_ram_vld & (~r_pf_vld | w_acc_pop);
  assign w_re     = IsFwft ? ((w_unread != '0) & (~r_ram_vld | w_move) & ~FLUSH) : w_acc_pop;

  always_comb begin
    w_level_d = r_level;
    if (FLUSH) begin
      w_level_d = '0;
    end else if (w_acc_push & ~w_acc_pop) begin
      w_level_d = r_level + LW'(1);
    end else if (w_acc_pop & ~w_acc_push) begin
      w_level_d = r_level - LW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_af      <= 1'b0;
      r_ae      <= 1'b1;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_dvalid  <= 1'b0;
      r_pf      <= '0;
      r_pf_vld  <= 1'b0;
      r_ram_vld <= 1'b0;
    end else begin
      r_level  <= w_level_d;
      r_full   <= (w_level_d == LW'(Depth));
      r_empty  <= (w_level_d == '0);
      r_af     <= (w_level_d >= LW'(AF_LEVEL));
      r_ae     <= (w_level_d <= LW'(AE_LEVEL));
      // A fresh error in the same cycle as CLR_ERR keeps the flag set.
      r_ovf    <= w_ovf_evt | (r_ovf & ~CLR_ERR);
      r_unf    <= w_unf_evt | (r_unf & ~CLR_ERR);
      r_dvalid <= ~IsFwft & w_acc_pop;
      if (FLUSH) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_pf_vld  <= 1'b0;
        r_ram_vld <= 1'b0;
      end else begin
        if (w_acc_push) begin
          r_wr_ptr <= r_wr_ptr + LW'(1);
        end
        if (w_re) begin
          r_rd_ptr <= r_rd_ptr + LW'(1);
        end
        if (w_move) begin
          r_pf     <= w_rdata;
          r_pf_vld <= 1'b1;
        end else if (w_acc_pop) begin
          r_pf_vld <= 1'b0;
        end
        if (w_re) begin
          r_ram_vld <= 1'b1;
        end else if (w_move) begin
          r_ram_vld <= 1'b0;
        end
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_EXP)
  ) u_ram (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .i_we    (w_acc_push),
    .i_waddr (r_wr_ptr[ADDR_EXP-1:0]),
    .i_wdata (DATA_IN),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr[ADDR_EXP-1:0]),
    .o_rdata (w_rdata)
  );

  assign DATA_OUT     = IsFwft ? r_pf : w_rdata;
  assign DATA_VALID   = IsFwft ? r_pf_vld : r_dvalid;
  assign FULL         = r_full;
  assign EMPTY        = w_empty;
  assign ALMOST_FULL  = r_af;
  assign ALMOST_EMPTY = r_ae;
  assign LEVEL        = r_level;
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_unf;

endmodule
